// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer for the 3-output gate generator: walks every a/b vector per selected gate,
// samples after a settle interval, streams one result record per vector and counts mismatches.
module gate_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] gate_sel,
   output logic       dut_a,
   output logic       dut_b,
   input  logic [2:0] dut_out,
   output logic       rec_valid,
   input  logic       rec_ready,
   output logic [7:0] rec_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_EMIT
   } state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_sel, w_sel_nxt;
   logic [1:0] r_gate, w_gate_nxt;
   logic       r_a, w_a_nxt;
   logic       r_b, w_b_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       r_valid, w_valid_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   logic [7:0] r_err, w_err_nxt;

   logic       w_obs;
   logic       w_exp;
   logic       w_pass;
   logic       w_gate_end;
   logic       w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= 2'd0;
         r_gate  <= 2'd0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_data  <= 8'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_gate  <= w_gate_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Case equality keeps an X/Z sample from the generator counted as a mismatch in simulation.
   always_comb begin
      w_obs = dut_out[r_gate];
      case (r_gate)
         2'd0:    w_exp = r_a;
         2'd1:    w_exp = ~(r_a & r_b);
         default: w_exp = ~(r_a ^ r_b);
      endcase
      w_pass     = (w_obs === w_exp);
      w_gate_end = (r_gate == 2'd0) ? r_a : (r_a & r_b);
      w_last     = w_gate_end && ((r_sel != 2'd3) || (r_gate == 2'd2));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_gate_nxt  = r_gate;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_sel_nxt   = gate_sel;
               w_gate_nxt  = (gate_sel == 2'd3) ? 2'd0 : gate_sel;
               w_a_nxt     = 1'b0;
               w_b_nxt     = 1'b0;
               w_cnt_nxt   = 4'd0;
               w_err_nxt   = 8'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == LP_CNT_LAST) begin
               w_data_nxt  = {r_gate, r_a, r_b, w_obs, w_exp, w_pass, w_last};
               w_valid_nxt = 1'b1;
               if (!w_pass && (r_err != 8'hFF)) begin
                  w_err_nxt = r_err + 8'd1;
               end
               w_state_nxt = ST_EMIT;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         ST_EMIT: begin
            if (rec_ready) begin
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = 4'd0;
               if (r_data[0]) begin
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  // buf only walks a (b stays 0); nand/xnor count through all four a/b pairs.
                  if (w_gate_end) begin
                     w_gate_nxt = r_gate + 2'd1;
                     w_a_nxt    = 1'b0;
                     w_b_nxt    = 1'b0;
                  end else if (r_gate == 2'd0) begin
                     w_a_nxt = 1'b1;
                  end else begin
                     {w_a_nxt, w_b_nxt} = {r_a, r_b} + 2'd1;
                  end
                  w_state_nxt = ST_SETTLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign dut_a     = r_a;
   assign dut_b     = r_b;
   assign rec_valid = r_valid;
   assign rec_data  = r_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err_count = r_err;

endmodule
